// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage.
//   ADDR_W_DEF / DATA_W_DEF : default PC and instruction widths
//   INSTR_BYTES             : PC increment per sequential fetch
//   fetch_entry_t           : {pc, instr} pair as seen by decode
package fetch_pkg;

    localparam int          ADDR_W_DEF  = 32;
    localparam int          DATA_W_DEF  = 32;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO with synchronous flush.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   flush           : drop all contents (wins over push/pop)
//   push, push_data : write one entry
//   pop             : remove the head entry
//   head_data       : current head entry (valid when count != 0)
//   count           : number of stored entries, 0..DEPTH
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW:0]   FULL_C  = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop: flush overrides both, a full FIFO only takes a push alongside a pop.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_pop_s  = pop && (count_r != {(PW+1){1'b0}});
            do_push_s = push && ((count_r != FULL_C) || do_pop_s);
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data;
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/fetch_unit_chk.sv
// fetch_unit_chk: simulation-only protocol checks for fetch_unit.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   rsp_valid  : memory response strobe
//   inflight   : outstanding request count
//   drop       : responses still to be discarded after a redirect
//   tag_count  : occupancy of the PC-tag queue
module fetch_unit_chk #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          reset,
    input logic          rsp_valid,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] drop,
    input logic [CW-1:0] tag_count
);

    // Memory must never answer a request that was never issued.
    rsp_needs_inflight: assert property (@(posedge clk) disable iff (!reset)
        rsp_valid |-> (inflight != {CW{1'b0}}));

    // Every live (non-dropped) outstanding request owns exactly one tag.
    tag_tracks_live: assert property (@(posedge clk) disable iff (!reset)
        tag_count == (inflight - drop));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the PC register and decode.
// Issues imem requests for the current pc under a credit scheme, tags each
// request with its pc, buffers in-order responses and hands them to decode
// over valid/ready. pcNext feeds the enable-less PC register: redirect target,
// pc+4 on an accepted request, otherwise hold.
// Ports:
//   clk, reset              : clock, synchronous active-low reset
//   pc / pcNext             : current and next PC
//   imem_req_*              : request channel (addr = pc)
//   imem_rsp_*              : in-order response channel
//   if_valid/if_instr/if_pc : decode output, id_ready accepts
//   redirect_valid/_pc      : single-cycle flush and new target
// Optional: FETCH_ALIGN_CHECK_EN adds sticky output fetch_fault and blocks
// fetching from a pc whose low two bits are non-zero.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pcNext,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic              fetch_fault
`endif
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0]             inflight_r;
    logic [CW-1:0]             drop_r;
    logic [CW-1:0]             inflight_nxt_s;
    logic [CW-1:0]             drop_nxt_s;
    logic [CW-1:0]             tag_count_s;
    logic [CW-1:0]             buf_count_s;
    logic [ADDR_W-1:0]         tag_head_s;
    logic [ADDR_W+DATA_W-1:0]  buf_head_s;
    logic                      misalign_s;
    logic                      credit_ok_s;
    logic                      req_valid_s;
    logic                      accept_s;
    logic                      rsp_keep_s;
    logic                      rsp_drop_s;
    logic                      if_valid_s;
    logic                      pop_s;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_r;
    assign misalign_s = (pc[1:0] != 2'b00);

    // Sticky misalignment flag, cleared by reset or a redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_r <= 1'b0;
        end else if (redirect_valid) begin
            fault_r <= 1'b0;
        end else if (misalign_s) begin
            fault_r <= 1'b1;
        end
    end

    assign fetch_fault = fault_r;
`else
    assign misalign_s = 1'b0;
`endif

    // Request credit, handshake and response classification. Credit uses only
    // registered counts, so id_ready never reaches imem_req_valid.
    always_comb begin
        credit_ok_s = (({1'b0, inflight_r} + {1'b0, buf_count_s}) < DEPTH_C);
        req_valid_s = reset && !redirect_valid && credit_ok_s && !misalign_s;
        accept_s    = req_valid_s && imem_req_ready;
        rsp_drop_s  = imem_rsp_valid && (drop_r != {CW{1'b0}});
        rsp_keep_s  = imem_rsp_valid && (drop_r == {CW{1'b0}});
        if_valid_s  = reset && (buf_count_s != {CW{1'b0}});
        pop_s       = if_valid_s && id_ready && !redirect_valid;
    end

    // Next PC for the PC register: reset value, redirect, advance or hold.
    always_comb begin
        pcNext = pc;
        if (!reset) begin
            pcNext = RESET_PC;
        end else if (redirect_valid) begin
            pcNext = redirect_pc;
        end else if (accept_s) begin
            pcNext = pc + ADDR_W'(INSTR_BYTES);
        end else begin
            pcNext = pc;
        end
    end

    // Outstanding/drop bookkeeping. A redirect marks everything still in
    // flight after this cycle as stale, which also covers back-to-back
    // redirects where a dropped response lands in the redirect cycle.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({accept_s, imem_rsp_valid})
            2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
            2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
            default: inflight_nxt_s = inflight_r;
        endcase
        drop_nxt_s = drop_r;
        if (redirect_valid) begin
            drop_nxt_s = inflight_nxt_s;
        end else if (rsp_drop_s) begin
            drop_nxt_s = drop_r - CNT_ONE;
        end else begin
            drop_nxt_s = drop_r;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_r <= {CW{1'b0}};
            drop_r     <= {CW{1'b0}};
        end else begin
            inflight_r <= inflight_nxt_s;
            drop_r     <= drop_nxt_s;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W)
    ) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (accept_s),
        .push_data (pc),
        .pop       (rsp_keep_s),
        .head_data (tag_head_s),
        .count     (tag_count_s)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_keep_s),
        .push_data ({tag_head_s, imem_rsp_data}),
        .pop       (pop_s),
        .head_data (buf_head_s),
        .count     (buf_count_s)
    );

    fetch_unit_chk #(
        .CW (CW)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .rsp_valid (imem_rsp_valid),
        .inflight  (inflight_r),
        .drop      (drop_r),
        .tag_count (tag_count_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc;
    assign if_valid       = if_valid_s;
    assign if_pc          = buf_head_s[ADDR_W+DATA_W-1:DATA_W];
    assign if_instr       = buf_head_s[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit. The bench plays
// PC register and instruction memory; a queue-level model (outstanding
// requests, delivered-instruction queue) predicts every output each cycle.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
    logic        fault_m;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pcNext         (pcNext),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        stale;
        int          cyc;
    } mem_req_t;

    mem_req_t     mem_q[$];
    fetch_entry_t exp_q[$];
    int           n_pass  = 0;
    int           n_total = 0;
    int           cyc     = 0;
    bit           rsp_en  = 1'b1;
    int           rsp_pct = 100;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    endtask

    // One clock: drive memory response, check outputs at negedge, advance model.
    task automatic run_cycle();
        logic        rsp_now;
        logic        exp_rv;
        logic        exp_ifv;
        logic        acc;
        logic [31:0] exp_pn;
        mem_req_t    e;
        fetch_entry_t h;
        rsp_now = 1'b0;
        if (rsp_en && mem_q.size() != 0) begin
            if (mem_q[0].cyc < cyc && $urandom_range(99) < rsp_pct) rsp_now = 1'b1;
        end
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_q[0].data : 32'h0;

        exp_rv = !redirect_valid && ((mem_q.size() + exp_q.size()) < DEPTH);
`ifdef FETCH_ALIGN_CHECK_EN
        if (pc[1:0] != 2'b00) exp_rv = 1'b0;
`endif
        acc     = exp_rv && imem_req_ready;
        exp_pn  = redirect_valid ? redirect_pc : (acc ? pc + 32'd4 : pc);
        exp_ifv = (exp_q.size() != 0);

        @(negedge clk);
        check("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_rv});
        check("req_addr", {32'd0, imem_req_addr}, {32'd0, pc});
        check("pcNext", {32'd0, pcNext}, {32'd0, exp_pn});
        check("if_valid", {63'd0, if_valid}, {63'd0, exp_ifv});
        if (exp_ifv) begin
            h = exp_q[0];
            check("if_pc", {32'd0, if_pc}, {32'd0, h.pc});
            check("if_instr", {32'd0, if_instr}, {32'd0, h.instr});
        end
`ifdef FETCH_ALIGN_CHECK_EN
        check("fetch_fault", {63'd0, fetch_fault}, {63'd0, fault_m});
`endif

        @(posedge clk);
        if (exp_ifv && id_ready && !redirect_valid) void'(exp_q.pop_front());
        if (rsp_now) begin
            e = mem_q.pop_front();
            if (!e.stale && !redirect_valid) exp_q.push_back('{pc: e.addr, instr: e.data});
        end
        if (redirect_valid) begin
            exp_q.delete();
            for (int i = 0; i < mem_q.size(); i++) mem_q[i].stale = 1'b1;
        end
        if (acc) mem_q.push_back('{addr: pc, data: instr_of(pc), stale: 1'b0, cyc: cyc});
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_valid) fault_m = 1'b0;
        else if (pc[1:0] != 2'b00) fault_m = 1'b1;
`endif
        cyc++;
        #1;
        pc = exp_pn;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        run_cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        pc             = 32'h40;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_m        = 1'b0;
`endif

        // Reset held for three cycles with pc=0x40.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_pcNext", {32'd0, pcNext}, 64'h0);
            check("rst_req_valid", {63'd0, imem_req_valid}, 64'h0);
            check("rst_if_valid", {63'd0, if_valid}, 64'h0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        pc    = 32'h0;

        // Streaming fetch, memory latency 1, decode always ready.
        rsp_en = 1'b1; rsp_pct = 100;
        repeat (10) run_cycle();

        // Decode stalls: credit caps requests, pcNext holds; then resume.
        id_ready = 1'b0;
        repeat (8) run_cycle();
        id_ready = 1'b1;
        repeat (6) run_cycle();

        // Two requests in flight when a redirect arrives: both dropped.
        rsp_en = 1'b0;
        repeat (4) run_cycle();
        redirect_to(32'h100);
        rsp_en = 1'b1;
        repeat (10) run_cycle();

        // Memory not ready for five cycles (drains outstanding), then ready.
        imem_req_ready = 1'b0;
        repeat (5) run_cycle();
        imem_req_ready = 1'b1;
        repeat (3) run_cycle();

        // PC wrap: fetch at 0xFFFFFFFC advances to 0.
        imem_req_ready = 1'b0;
        repeat (4) run_cycle();
        imem_req_ready = 1'b1;
        redirect_to(32'hFFFF_FFFC);
        repeat (6) run_cycle();

        // Back-to-back redirects with responses in flight.
        rsp_pct = 50;
        redirect_to(32'h300);
        redirect_to(32'h400);
        redirect_to(32'h500);
        repeat (12) run_cycle();

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned target blocks fetching and raises a sticky fault.
        redirect_to(32'h102);
        repeat (4) run_cycle();
        redirect_to(32'h200);
        repeat (6) run_cycle();
`endif

        // Randomized traffic, aligned redirect targets.
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(99) < 70);
            id_ready       = ($urandom_range(99) < 60);
            rsp_pct        = 60;
            redirect_valid = ($urandom_range(19) == 0);
            redirect_pc    = $urandom() & 32'hFFFF_FFFC;
            run_cycle();
        end
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        repeat (10) run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
